// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared constants, state enum and helpers for the HI/LO mult/div path
package muldiv_sequencer_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [4:0] ALU_MULTU = 5'b00111;
    localparam logic [4:0] ALU_MULT  = 5'b01000;
    localparam logic [4:0] ALU_DIV   = 5'b01111;
    localparam logic [4:0] ALU_DIVU  = 5'b10000;
    localparam logic [4:0] ALU_MTHI  = 5'b10001;
    localparam logic [4:0] ALU_MTLO  = 5'b10010;
    localparam logic [4:0] ALU_MFHI  = 5'b11010;
    localparam logic [4:0] ALU_MFLO  = 5'b11011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_e;

    function automatic logic is_hilo_op(input logic [4:0] code);
        case (code)
            ALU_MULTU, ALU_MULT, ALU_DIV, ALU_DIVU,
            ALU_MTHI, ALU_MTLO, ALU_MFHI, ALU_MFLO: is_hilo_op = 1'b1;
            default:                                is_hilo_op = 1'b0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        magnitude = (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply step or one restoring divide step
module muldiv_step
    import muldiv_sequencer_pkg::*;
(
    input  logic                 div_mode,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // acc holds {partial, multiplier} for mult and {remainder, dividend/quotient} for div
    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd} : '0);
        rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, opnd};
        if (div_mode) begin
            if (diff[WIDTH])
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            else
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle HI/LO multiply/divide sequencer with issue stall
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               signed_op;
    logic               sign_xor;

    muldiv_step u_step (
        .div_mode (state_q == ST_DIV),
        .acc_i    (acc_q),
        .opnd     (opnd_q),
        .acc_o    (step_acc)
    );

    assign busy  = (state_q != ST_IDLE);
    assign stall = start & is_hilo_op(alucontrol) & busy;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        is_div_d  = is_div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        signed_op = (alucontrol == ALU_MULT) || (alucontrol == ALU_DIV);
        sign_xor  = signed_op & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
        a_mag     = magnitude(srca, signed_op);
        b_mag     = magnitude(srcb, signed_op);
        prod      = qneg_q ? -acc_q : acc_q;
        quot      = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem       = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (alucontrol)
                        ALU_MULT, ALU_MULTU: begin
                            state_d  = ST_MUL;
                            acc_d    = {{WIDTH{1'b0}}, b_mag};
                            opnd_d   = a_mag;
                            qneg_d   = sign_xor;
                            is_div_d = 1'b0;
                            count_d  = '0;
                        end
                        ALU_DIV, ALU_DIVU: begin
                            if (srcb == '0) begin
                                hi_d   = srca;
                                lo_d   = '1;
                                done_d = 1'b1;
                            end else begin
                                state_d  = ST_DIV;
                                acc_d    = {{WIDTH{1'b0}}, a_mag};
                                opnd_d   = b_mag;
                                qneg_d   = sign_xor;
                                rneg_d   = signed_op & srca[WIDTH-1];
                                is_div_d = 1'b1;
                                count_d  = '0;
                            end
                        end
                        ALU_MTHI: hi_d = srca;
                        ALU_MTLO: lo_d = srca;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                acc_d   = step_acc;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1))
                    state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quot;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

endmodule
